// File: rtl/csr_uart_rx_pkg.sv
// Shared CSR peripheral definitions: bus addresses, receiver FSM states and the rx status word layout.
package csr_uart_rx_pkg;

    typedef enum logic [11:0] {
        CSR_UART    = 12'hBC0,
        CSR_LEDS    = 12'hBC1,
        CSR_TIMER   = 12'hBC2,
        CSR_UART_RX = 12'hBC3
    } csr_addr_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef struct packed {
        logic        empty;
        logic        ovf;
        logic        ferr;
        logic [20:0] rsvd;
        logic [7:0]  dat;
    } rx_csr_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 deserializer: 2-FF synchronizer plus a mid-bit sampling FSM.
// Emits a 1-cycle byte_valid on a good stop bit and frame_err on a low one.
module uart_rx_deser
    import csr_uart_rx_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(DIV);
    // Counter expires at zero, so loads are one less than the wanted period.
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_deser: DIV must be at least 4");
        end
    endgenerate

    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            expire;

    assign expire = (cnt_q == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = expire ? cnt_q : cnt_q - CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (expire) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (expire) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (expire) begin
                    state_d = sync2_q ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state_q == RX_STOP && expire) begin
            byte_valid = sync2_q;
            frame_err  = !sync2_q;
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/csr_uart_rx.sv
// CSR-mapped UART receiver: deserializer feeding a byte FIFO, status read and flag clear at one CSR address.
// Reads pop the pre-edge head; sticky ovf/ferr are cleared by writing 1s to bits 30/29.
module csr_uart_rx
    import csr_uart_rx_pkg::*;
#(
    parameter int          CLOCK_RATE = 100_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter logic [11:0] CSR_ADDR   = CSR_UART_RX,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        irq_rx
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);

    generate
        if (!is_pow2(FIFO_DEPTH)) begin : g_depth_check
            $error("csr_uart_rx: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic        byte_valid, frame_err;
    logic [7:0]  byte_data;

    uart_rx_deser #(
        .DIV (DIV)
    ) u_deser (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d;
    logic        empty, full, sel, pop, push, ovf_set;
    rx_csr_t     csr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign sel   = (addr == CSR_ADDR) && (read || write);
    assign pop   = sel && read && !empty;
    // A pop on a full FIFO frees the slot in the same edge, so the push still lands.
    assign push    = byte_valid && (!full || pop);
    assign ovf_set = byte_valid && full && !pop;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = (ovf_q  && !(sel && write && wdata[30])) || ovf_set;
        ferr_d   = (ferr_q && !(sel && write && wdata[29])) || frame_err;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= byte_data;
        end
    end

    always_comb begin
        csr       = '0;
        csr.empty = empty;
        csr.ovf   = ovf_q;
        csr.ferr  = ferr_q;
        csr.dat   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    end

    assign rdata  = sel ? csr : 32'h0;
    assign valid  = sel;
    assign irq_rx = !empty;

    logic unused_wdata;
    assign unused_wdata = ^{wdata[31], wdata[28:0]};

endmodule

// File: tb/tb_csr_uart_rx.sv
// Directed bench for csr_uart_rx at DIV=10: table of frame/CSR steps plus hand-written overflow and reset sequences.
module tb_csr_uart_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        read, write;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        rx;
    logic        irq_rx;

    int errors = 0;
    int checks = 0;

    csr_uart_rx #(
        .CLOCK_RATE (1_000_000),
        .BAUD_RATE  (100_000),
        .CSR_ADDR   (12'hBC3),
        .FIFO_DEPTH (16)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .read   (read),
        .write  (write),
        .wdata  (wdata),
        .addr   (addr),
        .rdata  (rdata),
        .valid  (valid),
        .rx     (rx),
        .irq_rx (irq_rx)
    );

    always #5 clk = ~clk;

    localparam int K_CSR    = 0;
    localparam int K_FRAME  = 1;
    localparam int K_BAD    = 2;
    localparam int K_GLITCH = 3;

    typedef struct {
        int          kind;
        logic [7:0]  dat;
        logic        rd;
        logic        wr;
        logic [11:0] ad;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] er;
        logic        ei;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int kind, logic [7:0] dat, logic rd, logic wr, logic [11:0] ad,
                                logic [31:0] wd, logic ev, logic [31:0] er, logic ei);
        vec_t v;
        v.kind = kind; v.dat = dat; v.rd = rd; v.wr = wr; v.ad = ad;
        v.wd = wd; v.ev = ev; v.er = er; v.ei = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
        @(negedge clk);
        drive(1'b0, 10);
        for (int b = 0; b < 8; b++) drive(d[b], 10);
        drive(stop_val, stop_len);
        drive(1'b1, 4);
    endtask

    task automatic csr(input logic rd, input logic wr, input logic [11:0] ad, input logic [31:0] wd,
                       output logic v, output logic [31:0] d, output logic irq);
        @(negedge clk);
        read = rd; write = wr; addr = ad; wdata = wd;
        #1;
        v = valid; d = rdata; irq = irq_rx;
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic csr_chk(input string name, input logic rd, input logic wr, input logic [11:0] ad,
                           input logic [31:0] wd, input logic ev, input logic [31:0] er, input logic ei);
        logic        v, irq;
        logic [31:0] d;
        csr(rd, wr, ad, wd, v, d, irq);
        chk({name, "_valid"}, {31'b0, v}, {31'b0, ev});
        chk({name, "_rdata"}, d, er);
        chk({name, "_irq"}, {31'b0, irq}, {31'b0, ei});
    endtask

    initial begin
        rstn = 1'b0; rx = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;

        // Test 1: good frame, read it, then read empty
        tbl.push_back(mk(K_FRAME, 8'h55, 0, 0, 12'h000, 32'h0, 0, 32'h0, 0));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h0000_0055, 1));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0));
        // Test 2: short low glitch is rejected
        tbl.push_back(mk(K_GLITCH, 8'h00, 0, 0, 12'h000, 32'h0, 0, 32'h0, 0));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0));
        // Test 3: framing error then good frame; write clears ferr
        tbl.push_back(mk(K_BAD, 8'hA5, 0, 0, 12'h000, 32'h0, 0, 32'h0, 0));
        tbl.push_back(mk(K_FRAME, 8'h3C, 0, 0, 12'h000, 32'h0, 0, 32'h0, 0));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h2000_003C, 1));
        tbl.push_back(mk(K_CSR, 8'h00, 0, 1, 12'hBC3, 32'h2000_0000, 1, 32'hA000_0000, 0));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0));
        // Test 5: other address is not claimed and does not pop
        tbl.push_back(mk(K_FRAME, 8'h12, 0, 0, 12'h000, 32'h0, 0, 32'h0, 0));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC0, 32'h0, 0, 32'h0000_0000, 1));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h0000_0012, 1));
        tbl.push_back(mk(K_CSR, 8'h00, 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0));

        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", {31'b0, irq_rx}, 32'h0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        csr_chk("reset_read", 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].kind)
                K_FRAME:  send_frame(tbl[i].dat, 1'b1, 10);
                K_BAD:    send_frame(tbl[i].dat, 1'b0, 30);
                K_GLITCH: begin
                    @(negedge clk);
                    drive(1'b0, 3);
                    drive(1'b1, 20);
                end
                default:  csr_chk($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].ad,
                                  tbl[i].wd, tbl[i].ev, tbl[i].er, tbl[i].ei);
            endcase
        end

        // Test 4: overflow with 17 frames into a 16-deep FIFO
        for (int f = 0; f < 17; f++) send_frame(8'(f), 1'b1, 10);
        for (int r = 0; r < 17; r++) begin
            if (r < 16)
                csr_chk($sformatf("ovf_rd%0d", r), 1, 0, 12'hBC3, 32'h0, 1, 32'h4000_0000 | 32'(r), 1);
            else
                csr_chk("ovf_rd16", 1, 0, 12'hBC3, 32'h0, 1, 32'hC000_0000, 0);
        end
        csr_chk("ovf_clear", 1, 1, 12'hBC3, 32'h4000_0000, 1, 32'hC000_0000, 0);
        csr_chk("ovf_after", 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0);

        // Test 6: reset mid-frame drops the FIFO and the partial frame
        send_frame(8'h77, 1'b1, 10);
        #1;
        chk("pre_rst_irq", {31'b0, irq_rx}, 32'h1);
        @(negedge clk);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 5);
        rstn = 1'b0;
        #1;
        chk("midrst_irq", {31'b0, irq_rx}, 32'h0);
        chk("midrst_valid", {31'b0, valid}, 32'h0);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("post_rst_irq", {31'b0, irq_rx}, 32'h0);
        send_frame(8'h81, 1'b1, 10);
        csr_chk("rst_rd0", 1, 0, 12'hBC3, 32'h0, 1, 32'h0000_0081, 1);
        csr_chk("rst_rd1", 1, 0, 12'hBC3, 32'h0, 1, 32'h8000_0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
